multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main sequencer for the multicycle RV32I core variant. It replaces the single-cycle decoder with a Moore FSM that steps one shared ALU and one unified instruction/data memory through Fetch, Decode, Execute, Memory and Writeback. It also decodes ALU operations and supports memory wait states through a ready handshake. It sits beside the multicycle datapath, which holds the PC, IR, OldPC, Data and ALUOut registers.

Parameters:
WAIT_EN, 1, when 1 the memory states stall until MemReady is high; when 0 MemReady is ignored and treated as 1.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
op  in  7  Instr[6:0] from IR
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completed the current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR and OldPC enable
ResultSrc  out  2  Result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  out  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  ALU op: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
RegWrite  out  1  register file write enable
Retire  out  1  one-cycle pulse in the last state of each instruction
Illegal  out  1  one-cycle pulse in Decode when the opcode is unsupported

Behaviour:
Reset and general rules
- Reset: synchronous, active-high. The state register loads FETCH.
- While reset is high, PCWrite, IRWrite, RegWrite, MemWrite, Retire and Illegal are forced to 0. All other outputs show their FETCH values.
- Reset asserted in any state aborts the instruction. No partial write occurs after the reset edge.
- All outputs are Moore outputs decoded from the state. The exceptions are PCWrite, which uses Zero in BEQ, and the MemReady gating described below.
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00.

ALUOp and ALUControl decode
- ALUOp is internal: 00 = add, 01 = sub, 10 = use funct.
- With ALUOp 10, funct3 selects the operation:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- Outputs not listed for a state are 0 (write enables) or 00 (mux selects).

States and transitions
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite and PCWrite are asserted only when MemReady = 1; the state then goes to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (computes the branch/jump target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - Anything else → FETCH, with Illegal = 1 and Retire = 0.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Goes to MEMREAD if op[5] = 0, else MEMWR.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Holds until MemReady = 1, then goes to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, Retire = 1. Goes to FETCH.
- MEMWR: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 for every cycle in this state. When MemReady = 1: Retire = 1 and the state goes to FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Goes to ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Goes to ALUWB.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1. Goes to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, Retire = 1. Goes to FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, PCWrite = Zero, Retire = 1. Goes to FETCH.

Latency with no wait states
- beq: 3 cycles.
- R-type, I-type, sw, jal: 4 cycles.
- lw: 5 cycles.
- Each cycle with MemReady = 0 adds one cycle in FETCH, MEMREAD or MEMWR.

Encoding and undefined inputs
- State encoding is 4-bit binary, FETCH = 0. Unused encodings go to FETCH.
- An X or illegal op must never assert MemWrite or RegWrite.

Decomposition:
- Shared package mc_pkg holds:
  - the state enumeration;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - ALUOp codes and ALUControl codes;
  - ResultSrc, ALUSrcA and ALUSrcB select codes.
- One sub-module, mc_aludec: combinational ALUOp/funct3/funct7b5/op5 → ALUControl.
- The FSM and the instruction decoder stay in multicycle_ctrl.

Test Plan:
- Reset held 2 cycles, then released with MemReady = 1 → state FETCH; first cycle IRWrite = 1, PCWrite = 1, ALUSrcB = 10; PCWrite/RegWrite/MemWrite = 0 during reset.
- lw (op 0000011), MemReady = 1 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 and ResultSrc = 01 on cycle 5; Retire = 1 exactly once.
- sw (op 0100011) with MemReady low for 2 cycles in MEMWR → MemWrite = 1 for 3 consecutive cycles, AdrSrc = 1, then FETCH; RegWrite never 1.
- R-type sub (op 0110011, funct3 000, funct7b5 = 1) → ALUControl = 001 in EXECR; the same with funct7b5 = 0 → 000; I-type addi with funct7b5 = 1 → 000.
- beq with Zero = 1 → PCWrite = 1 in BEQ; with Zero = 0 → PCWrite = 0; both return to FETCH after 3 cycles.
- Unsupported op 0000000 → Illegal pulse in DECODE, back to FETCH, no Retire. Separately, reset asserted in MEMWR with MemReady = 0 → next cycle FETCH, MemWrite = 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RV32I controller: state codes, opcodes,
// ALUOp/ALUControl codes and datapath mux select codes.
package mc_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_JAL     = 4'd8;
    localparam logic [3:0] S_ALUWB   = 4'd9;
    localparam logic [3:0] S_BEQ     = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] to the ALUControl code.
import mc_pkg::*;

module mc_aludec (
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi has no sub form, so funct7b5 only counts for R-type
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle RV32I core: steps the shared ALU and the
// unified memory through fetch/decode/execute/memory/writeback.
import mc_pkg::*;

module multicycle_ctrl #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Retire,
    output logic       Illegal
);

    logic [3:0] state;
    logic [3:0] state_nx;
    logic [3:0] st;
    logic [1:0] aluop;
    logic       rdy;

    assign rdy = WAIT_EN ? MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = IMM_I;
            OP_SW:       ImmSrc = IMM_S;
            OP_BEQ:      ImmSrc = IMM_B;
            OP_JAL:      ImmSrc = IMM_J;
            default:     ImmSrc = IMM_I;
        endcase
    end

    always_comb begin
        // Under reset the outputs show FETCH decoding whatever the state register holds
        st        = reset ? S_FETCH : state;
        state_nx  = S_FETCH;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        aluop     = ALUOP_ADD;
        RegWrite  = 1'b0;
        Retire    = 1'b0;
        Illegal   = 1'b0;
        case (st)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (rdy) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    state_nx = S_DECODE;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_R:         state_nx = S_EXECR;
                    OP_I:         state_nx = S_EXECI;
                    OP_JAL:       state_nx = S_JAL;
                    OP_BEQ:       state_nx = S_BEQ;
                    default: begin
                        Illegal  = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                state_nx = op[5] ? S_MEMWR : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc   = 1'b1;
                state_nx = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = rdy;
                state_nx = rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                ALUSrcA  = SRCA_RD1;
                aluop    = ALUOP_FUNCT;
                state_nx = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                aluop    = ALUOP_FUNCT;
                state_nx = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCWrite  = 1'b1;
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_SUB;
                PCWrite = Zero;
                Retire  = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Retire   = 1'b0;
            Illegal  = 1'b0;
        end
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full output vector against hand-derived values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [17:0] obs;
    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.WAIT_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .Retire     (Retire),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, RegWrite, Retire, Illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Field order: pcw adr mw irw | ResultSrc ALUSrcA ALUSrcB ImmSrc | ALUControl | rw ret ill
    task automatic chk(input string tag, input logic pcw, input logic adr, input logic mw,
                       input logic irw, input logic [1:0] rs, input logic [1:0] asa,
                       input logic [1:0] asb, input logic [1:0] imm, input logic [2:0] alc,
                       input logic rw, input logic ret, input logic ill);
        logic [17:0] e;
        #1;
        e = {pcw, adr, mw, irw, rs, asa, asb, imm, alc, rw, ret, ill};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, e);
        end
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; MemReady = 1'b1;

        // Reset held two cycles: FETCH selects, all enables forced low
        chk("rst_c0", 0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0,0);
        tick();
        chk("rst_c1", 0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0,0);
        tick();

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        reset = 1'b0; op = 7'b0000011; funct3 = 3'b010;
        chk("lw_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0,0);
        tick();
        chk("lw_decode",  0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0,0,0);
        tick();
        chk("lw_memadr",  0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0,0,0);
        tick();
        chk("lw_memread", 0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0,0);
        tick();
        chk("lw_memwb",   0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b000, 1,1,0);
        tick();

        // sw with one fetch stall and two MEMWR wait cycles
        op = 7'b0100011; MemReady = 1'b0;
        chk("sw_fetch_stall", 0,0,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0,0);
        tick();
        MemReady = 1'b1;
        chk("sw_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0,0);
        tick();
        chk("sw_decode",  0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000, 0,0,0);
        tick();
        chk("sw_memadr",  0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000, 0,0,0);
        tick();
        MemReady = 1'b0;
        chk("sw_memwr_w0", 0,1,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,0,0);
        tick();
        chk("sw_memwr_w1", 0,1,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,0,0);
        tick();
        MemReady = 1'b1;
        chk("sw_memwr_done", 0,1,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,1,0);
        tick();

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        chk("sub_fetch",  1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0,0);
        tick();
        chk("sub_decode", 0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0,0,0);
        tick();
        chk("sub_execr",  0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b001, 0,0,0);
        tick();
        chk("sub_aluwb",  0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,1,0);
        tick();

        // R-type add, then and/or/slt in EXECR (funct3 changes only on the EXECR cycle)
        funct7b5 = 1'b0;
        tick(); tick();
        chk("add_execr",  0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b000, 0,0,0);
        tick(); tick();
        tick(); tick();
        funct3 = 3'b111;
        chk("and_execr",  0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b010, 0,0,0);
        funct3 = 3'b110;
        chk("or_execr",   0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b011, 0,0,0);
        funct3 = 3'b010;
        chk("slt_execr",  0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b101, 0,0,0);
        tick(); tick();

        // addi with funct7b5 set must still add
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        chk("addi_execi", 0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0,0,0);
        tick();
        chk("addi_aluwb", 0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,1,0);
        tick();

        // beq taken then not taken, three cycles each
        op = 7'b1100011; funct7b5 = 1'b0; Zero = 1'b1;
        chk("beq1_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0,0,0);
        tick();
        chk("beq1_decode", 0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0,0,0);
        tick();
        chk("beq1_taken", 1,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001, 0,1,0);
        tick();
        Zero = 1'b0;
        chk("beq0_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0,0,0);
        tick(); tick();
        chk("beq0_nottaken", 0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001, 0,1,0);
        tick();

        // jal
        op = 7'b1101111;
        tick(); tick();
        chk("jal_jal",    1,0,0,0, 2'b00,2'b01,2'b10,2'b11, 3'b000, 0,0,0);
        tick();
        chk("jal_aluwb",  0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 3'b000, 1,1,0);
        tick();

        // unsupported opcode: Illegal in DECODE, no Retire, straight back to FETCH
        op = 7'b0000000;
        chk("ill_fetch",  1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0,0);
        tick();
        chk("ill_decode", 0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0,0,1);
        tick();
        chk("ill_refetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0,0);
        tick();
        tick();

        // reset while MEMWR is waiting aborts the store
        op = 7'b0100011;
        tick(); tick(); tick();
        MemReady = 1'b0;
        chk("abort_memwr", 0,1,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,0,0);
        tick();
        reset = 1'b1;
        chk("abort_in_rst", 0,0,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0,0);
        tick();
        reset = 1'b0; MemReady = 1'b1;
        chk("abort_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0,0);
        tick();
        chk("abort_decode", 0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000, 0,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
